rc4_core_scheduler: RTL and testbench

// - Top-level sequencer for NUM_CORES parallel rc4_encapsulated brute-force cores.
// - Drives each core's init value, core count, reset, start and stop_all.
// - Watches every core's correct_key_found and secret_key; the lowest-index core that

---
 rtl/rc4_core_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_rc4_core_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rc4_core_scheduler.sv
// rtl/rc4_core_scheduler.sv - sequencer and result arbiter for parallel RC4 brute-force cores
//
// Purpose: resets and launches NUM_CORES search cores, then watches them for a
// key hit (lowest core index wins) or for every core wrapping its 22-bit key
// counter (search exhausted).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      single-cycle command pulses (abort has priority)
//   core_found        per-core key-found flags
//   core_key          per-core current key, core i at [24*i+23:24*i]
//   core_init_val     constant per-core init value (core i gets i)
//   total_cores       constant core count
//   core_reset        active-high reset to all cores
//   core_start        one-cycle launch pulse to all cores
//   stop_all          halt all cores
//   busy              search in progress
//   found, exhausted  sticky search results
//   winner_idx        index of winning core
//   found_key         latched key of the winner
//   run_cycles        saturating count of RUN cycles

module rc4_core_scheduler #(
  parameter int NUM_CORES    = 4,
  parameter int RESET_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [NUM_CORES*24-1:0] core_key,
  output logic [NUM_CORES*8-1:0]  core_init_val,
  output logic [7:0]              total_cores,
  output logic                    core_reset,
  output logic                    core_start,
  output logic                    stop_all,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [2:0]              winner_idx,
  output logic [23:0]             found_key,
  output logic [31:0]             run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_CORES,
    S_LAUNCH,
    S_RUN,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    core_reset_q, core_reset_d;
  logic                    found_q, found_d;
  logic                    exhausted_q, exhausted_d;
  logic [2:0]              winner_q, winner_d;
  logic [23:0]             key_q, key_d;
  logic [31:0]             run_q, run_d;
  logic [NUM_CORES-1:0]    wrapped_q, wrapped_d;
  logic [NUM_CORES*24-1:0] prev_q, prev_d;

  logic [2:0]              hit_idx;
  logic [23:0]             hit_key;
  logic [NUM_CORES-1:0]    wrap_now;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_init
    assign core_init_val[8*g +: 8] = 8'(g);
  end
  assign total_cores = 8'(NUM_CORES);

  // Lowest-index priority: scan downwards so the smallest set index is written last.
  always_comb begin
    hit_idx = '0;
    hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        hit_idx = 3'(i);
        hit_key = core_key[24*i +: 24];
      end
    end
  end

  // A counter wrap shows up as the low 22 key bits going backwards; bits [23:22] are ignored.
  always_comb begin
    wrap_now = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      wrap_now[i] = core_key[24*i +: 22] < prev_q[24*i +: 22];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_reset_d = 1'b0;
    found_d      = found_q;
    exhausted_d  = exhausted_q;
    winner_d     = winner_q;
    key_d        = key_q;
    run_d        = run_q;
    wrapped_d    = wrapped_q;
    prev_d       = prev_q;

    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d      = S_RST_CORES;
          cnt_d        = 8'(RESET_CYCLES - 1);
          core_reset_d = 1'b1;
          found_d      = 1'b0;
          exhausted_d  = 1'b0;
          winner_d     = '0;
          key_d        = '0;
          run_d        = '0;
          wrapped_d    = '0;
        end
      end

      S_RST_CORES: begin
        if (abort) begin
          state_d      = S_IDLE;
          core_reset_d = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = S_LAUNCH;
        end else begin
          cnt_d        = cnt_q - 8'd1;
          core_reset_d = 1'b1;
        end
      end

      S_LAUNCH: begin
        if (abort) begin
          state_d      = S_IDLE;
          core_reset_d = 1'b1;
        end else begin
          state_d = S_RUN;
          prev_d  = core_key;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Results and cycle count freeze; cores get a one-cycle reset pulse.
          state_d      = S_IDLE;
          core_reset_d = 1'b1;
        end else begin
          prev_d    = core_key;
          wrapped_d = wrapped_q | wrap_now;
          if (run_q != 32'hFFFF_FFFF) run_d = run_q + 32'd1;
          // A hit outranks exhaustion seen in the same cycle.
          if (|core_found) begin
            state_d  = S_FOUND;
            found_d  = 1'b1;
            winner_d = hit_idx;
            key_d    = hit_key;
          end else if (&wrapped_d) begin
            state_d     = S_EXHAUSTED;
            exhausted_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;  // cores stay in reset while the scheduler is
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      winner_q     <= '0;
      key_q        <= '0;
      run_q        <= '0;
      wrapped_q    <= '0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
      winner_q     <= winner_d;
      key_q        <= key_d;
      run_q        <= run_d;
      wrapped_q    <= wrapped_d;
      prev_q       <= prev_d;
    end
  end

  assign core_reset = core_reset_q;
  assign core_start = (state_q == S_LAUNCH);
  assign stop_all   = (state_q == S_FOUND) || (state_q == S_EXHAUSTED);
  assign busy       = (state_q == S_RST_CORES) || (state_q == S_LAUNCH) || (state_q == S_RUN);
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign winner_idx = winner_q;
  assign found_key  = key_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_rc4_core_scheduler.sv
// tb/tb_rc4_core_scheduler.sv - directed scoreboard bench for rc4_core_scheduler
module tb_rc4_core_scheduler;
  localparam int NC = 4;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [NC-1:0] core_found;
  logic [NC*24-1:0] core_key;
  logic [NC*8-1:0]  core_init_val;
  logic [7:0]    total_cores;
  logic          core_reset, core_start, stop_all, busy, found, exhausted;
  logic [2:0]    winner_idx;
  logic [23:0]   found_key;
  logic [31:0]   run_cycles;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        f;
    logic        e;
    logic [2:0]  w;
    logic [23:0] k;
  } exp_t;
  exp_t sb[$];

  rc4_core_scheduler #(.NUM_CORES(NC), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .core_found(core_found), .core_key(core_key),
    .core_init_val(core_init_val), .total_cores(total_cores),
    .core_reset(core_reset), .core_start(core_start), .stop_all(stop_all),
    .busy(busy), .found(found), .exhausted(exhausted),
    .winner_idx(winner_idx), .found_key(found_key), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int i, input logic [23:0] v);
    core_key[24*i +: 24] = v;
  endtask

  task automatic push(input logic f, input logic e, input logic [2:0] w, input logic [23:0] k);
    exp_t x;
    x.f = f; x.e = e; x.w = w; x.k = k;
    sb.push_back(x);
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_found"},     32'(found),      32'(x.f));
      chk({tag, "_exhausted"}, 32'(exhausted),  32'(x.e));
      chk({tag, "_winner"},    32'(winner_idx), 32'(x.w));
      chk({tag, "_key"},       32'(found_key),  32'(x.k));
      chk({tag, "_stop_all"},  32'(stop_all),   32'd1);
      chk({tag, "_busy"},      32'(busy),       32'd0);
    end
  endtask

  // Start pulse, then RC cycles of core_reset, core_start in cycle RC+1, then RUN.
  task automatic launch(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_run_clr"},   run_cycles, 32'd0);
    chk({tag, "_found_clr"}, 32'(found), 32'd0);
    chk({tag, "_exh_clr"},   32'(exhausted), 32'd0);
    for (int c = 1; c <= RC; c++) begin
      chk($sformatf("%s_rst_c%0d", tag, c),   32'(core_reset), 32'd1);
      chk($sformatf("%s_nostart_c%0d", tag, c), 32'(core_start), 32'd0);
      chk($sformatf("%s_busy_c%0d", tag, c),  32'(busy), 32'd1);
      @(negedge clk);
    end
    chk({tag, "_core_start"}, 32'(core_start), 32'd1);
    chk({tag, "_rst_low"},    32'(core_reset), 32'd0);
    @(negedge clk);
    chk({tag, "_start_low"},  32'(core_start), 32'd0);
    chk({tag, "_run_busy"},   32'(busy), 32'd1);
  endtask

  task automatic all_high();
    for (int i = 0; i < NC; i++) set_key(i, 24'h3FFFFE);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; core_found = '0; core_key = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_stop_all",   32'(stop_all),   32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_found",      32'(found),      32'd0);
    chk("rst_exhausted",  32'(exhausted),  32'd0);
    chk("rst_winner",     32'(winner_idx), 32'd0);
    chk("rst_key",        32'(found_key),  32'd0);
    chk("rst_run",        run_cycles,      32'd0);
    chk("init_val",       core_init_val,   32'h0302_0100);
    chk("total_cores",    32'(total_cores), 32'd4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_core_reset", 32'(core_reset), 32'd0);

    // Single hit on core 2
    launch("l1");
    set_key(2, 24'h000A5C); core_found = 4'b0100;
    push(1'b1, 1'b0, 3'd2, 24'h000A5C);
    @(negedge clk); core_found = '0;
    pop_check("hit2");

    // abort from FOUND keeps results
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_found_stop", 32'(stop_all), 32'd0);
    chk("abort_found_keep", 32'(found), 32'd1);
    chk("abort_found_key",  32'(found_key), 32'h000A5C);

    // Simultaneous hits on cores 1 and 3; bits [23:22] kept in the key
    launch("l2");
    set_key(1, 24'hC12345); set_key(3, 24'h000777); core_found = 4'b1010;
    push(1'b1, 1'b0, 3'd1, 24'hC12345);
    @(negedge clk); core_found = '0;
    pop_check("hit13");

    // Exhaustion: cores wrap one per cycle; core 2 wraps into a key with top bits set
    launch("l3");
    all_high();
    set_key(0, 24'h000005); @(negedge clk);
    set_key(1, 24'h000005); @(negedge clk);
    set_key(2, 24'hC00001); @(negedge clk);
    chk("exh_not_yet", 32'(exhausted), 32'd0);
    chk("exh_busy",    32'(busy), 32'd1);
    set_key(3, 24'h000002);
    push(1'b0, 1'b1, 3'd0, 24'h000000);
    @(negedge clk);
    pop_check("exh");

    // Last wrap coincides with a hit on core 0: hit wins
    launch("l4");
    all_high();
    set_key(0, 24'h000005); @(negedge clk);
    set_key(1, 24'h000005); @(negedge clk);
    set_key(2, 24'h000005); @(negedge clk);
    set_key(3, 24'h000005); core_found = 4'b0001;
    push(1'b1, 1'b0, 3'd0, 24'h000005);
    @(negedge clk); core_found = '0;
    pop_check("hit_vs_exh");

    // Abort 10 cycles into RUN
    launch("l5");
    guard = 0;
    while (run_cycles != 32'd10 && guard < 100) begin
      @(negedge clk); guard++;
    end
    chk("run10_reached", 32'(guard < 100), 32'd1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_rst_pulse", 32'(core_reset), 32'd1);
    chk("abort_busy",      32'(busy), 32'd0);
    chk("abort_stop",      32'(stop_all), 32'd0);
    chk("abort_run_held",  run_cycles, 32'd10);
    core_found = 4'b1111;  // stray hit outside RUN must be ignored
    @(negedge clk);
    chk("abort_rst_end",   32'(core_reset), 32'd0);
    chk("abort_run_held2", run_cycles, 32'd10);
    core_found = '0;
    @(negedge clk);
    chk("stray_ignored",   32'(found), 32'd0);
    chk("idle_stop",       32'(stop_all), 32'd0);

    // Restart after abort
    launch("l6");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
